// File: rtl/triram_arbiter.sv
// triram_arbiter: two-requester front end for triram.
// Serialises instruction fetch (F) and data load/store (D) onto triram's
// single access port, captures completions into per-requester result
// registers and slots MMU cache invalidation between accesses.
// Optional feature: define TRIRAM_ARB_RR_EN for round-robin arbitration;
// without it data has fixed priority over fetch.
module triram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [17:0] f_addr,
  output logic        f_done,
  output logic        f_pagefault,
  output logic [17:0] f_out,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [17:0] d_addr,
  input  logic [17:0] d_in,
  output logic        d_done,
  output logic        d_pagefault,
  output logic [17:0] d_out,
  input  logic        inv_req,
  output logic        inv_ack,
  output logic        m_e,
  output logic        m_write,
  output logic [1:0]  m_pt,
  output logic [17:0] m_addr,
  output logic [17:0] m_in,
  input  logic        m_o,
  input  logic        m_pagefault,
  input  logic [17:0] m_out,
  output logic        m_invalidate
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_owner_wr;
  logic        r_inv_pend;
  logic        r_inv_ack;
  logic        r_f_done;
  logic        r_f_pf;
  logic [17:0] r_f_out;
  logic        r_d_done;
  logic        r_d_pf;
  logic [17:0] r_d_out;
`ifdef TRIRAM_ARB_RR_EN
  logic        r_last;
`endif

  logic        w_complete;
  logic        w_idle;
  logic        w_f_elig;
  logic        w_d_elig;
  logic        w_inv_fire;
  logic        w_issue;
  logic        w_grant;

  // The m_o cycle of an outstanding access behaves as IDLE for issue and
  // invalidation; m_o seen in IDLE is ignored.
  assign w_complete = (r_state == ST_BUSY) && m_o;
  assign w_idle     = (r_state == ST_IDLE) || w_complete;

  // A requester is ignored in its own m_o cycle and in its done cycle,
  // where its req is necessarily still high from the finished access.
  assign w_f_elig = f_req && !r_f_done && !(w_complete && (r_owner == OWN_F));
  assign w_d_elig = d_req && !r_d_done && !(w_complete && (r_owner == OWN_D));

  // Invalidation only fires with nothing outstanding and blocks issue.
  assign w_inv_fire = w_idle && r_inv_pend;
  assign w_issue    = w_idle && !r_inv_pend && (w_f_elig || w_d_elig);

  // Select which eligible requester wins this cycle.
  always_comb begin
    w_grant = OWN_D;
    if (w_f_elig && w_d_elig) begin
`ifdef TRIRAM_ARB_RR_EN
      w_grant = (r_last == OWN_D) ? OWN_F : OWN_D;
`else
      w_grant = OWN_D;
`endif
    end else if (w_f_elig) begin
      w_grant = OWN_F;
    end else begin
      w_grant = OWN_D;
    end
  end

  // State register: IDLE/BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: issue enters BUSY; completion without back-to-back issue
  // returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_o) begin
          w_state_nxt = w_issue ? ST_BUSY : ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request-side outputs: triram fields driven straight from the granted
  // held request during the single issue cycle.
  always_comb begin
    m_e          = 1'b0;
    m_write      = 1'b0;
    m_pt         = 2'b00;
    m_addr       = 18'h00000;
    m_in         = 18'h00000;
    m_invalidate = w_inv_fire;
    if (w_issue) begin
      m_e = 1'b1;
      if (w_grant == OWN_D) begin
        m_write = d_write;
        m_pt    = d_write ? 2'b00 : 2'b01;
        m_addr  = d_addr;
        m_in    = d_in;
      end else begin
        m_write = 1'b0;
        m_pt    = 2'b11;
        m_addr  = f_addr;
        m_in    = 18'h00000;
      end
    end else begin
      m_e = 1'b0;
    end
  end

  // Remember who owns the outstanding access (and the last grant).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWN_F;
      r_owner_wr <= 1'b0;
`ifdef TRIRAM_ARB_RR_EN
      r_last     <= OWN_F;
`endif
    end else if (w_issue) begin
      r_owner    <= w_grant;
      r_owner_wr <= (w_grant == OWN_D) && d_write;
`ifdef TRIRAM_ARB_RR_EN
      r_last     <= w_grant;
`endif
    end else begin
      r_owner    <= r_owner;
      r_owner_wr <= r_owner_wr;
`ifdef TRIRAM_ARB_RR_EN
      r_last     <= r_last;
`endif
    end
  end

  // Invalidation pending flag and acknowledge; a pulse arriving while
  // pending (including the firing cycle) merges into the same flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv_pend <= 1'b0;
      r_inv_ack  <= 1'b0;
    end else begin
      r_inv_ack <= w_inv_fire;
      if (w_inv_fire) begin
        r_inv_pend <= 1'b0;
      end else if (inv_req) begin
        r_inv_pend <= 1'b1;
      end else begin
        r_inv_pend <= r_inv_pend;
      end
    end
  end

  // Capture completion into the owner's result registers; done follows
  // one cycle after m_o. Data writes leave d_out untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_done <= 1'b0;
      r_f_pf   <= 1'b0;
      r_f_out  <= 18'h00000;
      r_d_done <= 1'b0;
      r_d_pf   <= 1'b0;
      r_d_out  <= 18'h00000;
    end else begin
      r_f_done <= w_complete && (r_owner == OWN_F);
      r_d_done <= w_complete && (r_owner == OWN_D);
      if (w_complete && (r_owner == OWN_F)) begin
        r_f_pf  <= m_pagefault;
        r_f_out <= m_out;
      end else begin
        r_f_pf  <= r_f_pf;
        r_f_out <= r_f_out;
      end
      if (w_complete && (r_owner == OWN_D)) begin
        r_d_pf  <= m_pagefault;
        r_d_out <= r_owner_wr ? r_d_out : m_out;
      end else begin
        r_d_pf  <= r_d_pf;
        r_d_out <= r_d_out;
      end
    end
  end

  assign f_done      = r_f_done;
  assign f_pagefault = r_f_pf;
  assign f_out       = r_f_out;
  assign d_done      = r_d_done;
  assign d_pagefault = r_d_pf;
  assign d_out       = r_d_out;
  assign inv_ack     = r_inv_ack;

endmodule

// File: doc/triram_arbiter.md
# triram_arbiter

Two-port front end for `triram`, sharing its single access port between instruction fetch and data load/store. It serialises requests and drives triram's one-cycle `e` pulse. It captures the `o`/`pagefault`/`out` completion into per-requester result registers and sequences MMU cache invalidation so that invalidation never overlaps an outstanding access. It sits between the CPU core and `triram`.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `f_req` in 1: fetch request; held with `f_addr` stable until `f_done`.
- `f_addr` in 18: fetch address (tryte); always issued as pt = X (2'b11), read.
- `f_done` out 1: one-cycle completion pulse for fetch.
- `f_pagefault` out 1: valid with `f_done`.
- `f_out` out 18: fetched word; held until the next `f_done`.
- `d_req` in 1: data request; held with `d_write`, `d_addr`, `d_in` stable until `d_done`.
- `d_write` in 1: 0 = read (pt R, 2'b01), 1 = write (pt W, 2'b00).
- `d_addr` in 18: data address.
- `d_in` in 18: write data.
- `d_done` out 1: one-cycle completion pulse for data.
- `d_pagefault` out 1: valid with `d_done`.
- `d_out` out 18: read data; held until the next `d_done`; unchanged by writes.
- `inv_req` in 1: request MMU cache invalidation; single-cycle pulse.
- `inv_ack` out 1: one-cycle pulse when invalidation has been applied.
- `m_e` `m_write` out 1/1, `m_pt` out 2, `m_addr` `m_in` out 18/18: triram request side.
- `m_o` `m_pagefault` in 1/1, `m_out` in 18: triram completion side.
- `m_invalidate` out 1: drives triram `invalidate_cache`.

## Operation
- States: IDLE (no access outstanding) and BUSY (one access issued, awaiting `m_o`). Owner register records F or D.
- Issue: in IDLE, with no invalidation pending, an eligible requester is selected. `m_e` pulses for exactly that cycle with its fields driven combinationally from the held request. The owner is latched and the state moves to BUSY.
- Completion: in BUSY with `m_o`=1, `m_out` and `m_pagefault` are registered into the owner's result registers. The owner's `*_done` pulses on the next cycle.
  - The state returns to IDLE in the same cycle as `m_o`.
  - The other requester may be issued in that same cycle (back-to-back).
- Eligibility: a requester is not eligible in the `m_o` cycle of its own access or in its `*_done` cycle. Its `req` is still high there and is ignored. Requesters must drop `req` by the cycle after `*_done` or it is treated as a new request.
- Pagefault: delivered as a normal completion with `*_pagefault`=1.
  - `d_out` and `f_out` are updated with `m_out` regardless; the content is don't-care but deterministic.
  - No retry.
- Invalidation: `inv_req` sets a pending flag, and a second pulse while pending merges into it.
  - When pending and the state is IDLE, `m_invalidate` is asserted for one cycle.
  - No `m_e` is issued in that cycle.
  - `inv_ack` pulses in the following cycle and the flag clears.
  - Pending invalidation has priority over new issues. The `m_o` cycle counts as IDLE for this purpose.
- `m_o` while in IDLE is a protocol error: ignored, no done.

## Timing
- Reset: state IDLE; pending flag, owner, and the last-grant pointer cleared. All `*_done`, `inv_ack`, `m_e`, `m_invalidate` = 0. `f_out`, `d_out` = 0; `f_pagefault`, `d_pagefault` = 0.
- Reset mid-access: the outstanding access is abandoned with no done pulse. triram is reset by the same `rst`.
- Latency from `req` rising in IDLE (cycle N): `m_e` at N.
  - triram direct or cache hit: `m_o` at N+1, `*_done` at N+2.
  - PTE miss: `m_o` at N+2, `*_done` at N+3.
- Throughput: alternating requesters can issue one access per `m_o`, i.e. every 1–2 cycles.
- `m_e` is never asserted in BUSY except in the `m_o` cycle.

## Configuration
- `TRIRAM_ARB_RR_EN` defined: round-robin. On simultaneous eligible requests, grant the requester not granted last. The last-grant pointer updates on each issue.
- Not defined: fixed priority, data over fetch. Fetch can starve under continuous data traffic.

## Test plan
- Fetch only, triram hit: `f_req`=1, `f_addr`=18'h00155, direct mode at cycle N → `m_e`/`m_pt`=2'b11 at N; `f_done`=1, `f_pagefault`=0 at N+2; `f_out` = memory word.
- Data write then read same address: `d_write`=1, `d_in`=18'h15555 → `d_done`; then a read → `d_out`=18'h15555. `f_out` is unchanged throughout.
- Simultaneous `f_req` and `d_req` in IDLE, both held:
  - Without the macro, D is issued first, then F is issued in D's `m_o` cycle.
  - With the macro, grants alternate F/D across 4 consecutive transactions.
- `inv_req` pulse during a PTE-miss access: `m_invalidate` is asserted only in the `m_o` cycle and no `m_e` is issued then; `inv_ack` follows one cycle later; the pending data request issues the cycle after.
- Pagefault: the PTE denies R, so `m_pagefault`=1 → `d_done`=1, `d_pagefault`=1; the next request completes normally with `d_pagefault`=0.
- `rst` asserted in BUSY: the next cycle shows IDLE, with no `*_done` and outputs at their reset values; a new `f_req` issues normally afterwards.
